// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of async sig_in over a GATE_CYCLES window (optional BCD: FREQ_METER_BCD_EN).
// Latency: freq_vld 2 cycles after the last gate cycle, plus CNT_W cycles when BCD conversion is built in.
// Backpressure: none; start is dropped while busy, results are strobed once and held until the next strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 12000000,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int CONTINUOUS  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_ovf,
    output logic             freq_vld,
    output logic [31:0]      freq_bcd
);

    localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
`ifdef FREQ_METER_BCD_EN
        ,
        CONV = 2'd3
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [GC_W-1:0]        gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       freq_cnt_q, freq_cnt_d;
    logic                   freq_ovf_q, freq_ovf_d;
    logic                   freq_vld_q, freq_vld_d;
    logic                   sig_rise;

    assign sig_rise = sync_q[SYNC_STAGES-1] & ~dly_q;

`ifdef FREQ_METER_BCD_EN
    localparam int CV_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    logic [CNT_W-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d, bcd_adj;
    logic [31:0]      freq_bcd_q, freq_bcd_d;
    logic [CV_W-1:0]  conv_cnt_q, conv_cnt_d;

    // Double-dabble correction: any digit of 5+ would exceed 9 after doubling.
    function automatic logic [31:0] dabble_adj(input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    assign bcd_adj  = dabble_adj(bcd_q);
    assign freq_bcd = freq_bcd_q;
`else
    assign freq_bcd = 32'd0;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        dly_d      = sync_q[SYNC_STAGES-1];
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        freq_cnt_d = freq_cnt_q;
        freq_ovf_d = freq_ovf_q;
        freq_vld_d = 1'b0;
`ifdef FREQ_METER_BCD_EN
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        conv_cnt_d = conv_cnt_q;
        freq_bcd_d = freq_bcd_q;
`endif
        case (state_q)
            IDLE: begin
                if (start || (CONTINUOUS != 0)) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            GATE: begin
                gate_cnt_d = gate_cnt_q + GC_W'(1);
                if (sig_rise) begin
                    if (&edge_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (gate_cnt_q == GC_W'(GATE_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef FREQ_METER_BCD_EN
                bin_d      = edge_cnt_q;
                bcd_d      = '0;
                conv_cnt_d = '0;
                state_d    = CONV;
`else
                freq_cnt_d = edge_cnt_q;
                freq_ovf_d = ovf_q;
                freq_vld_d = 1'b1;
                state_d    = IDLE;
`endif
            end
`ifdef FREQ_METER_BCD_EN
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                conv_cnt_d     = conv_cnt_q + CV_W'(1);
                if (conv_cnt_q == CV_W'(CNT_W - 1)) begin
                    freq_cnt_d = edge_cnt_q;
                    freq_ovf_d = ovf_q;
                    freq_bcd_d = bcd_d;
                    freq_vld_d = 1'b1;
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            dly_q      <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            freq_cnt_q <= '0;
            freq_ovf_q <= 1'b0;
            freq_vld_q <= 1'b0;
`ifdef FREQ_METER_BCD_EN
            bin_q      <= '0;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            freq_bcd_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            dly_q      <= dly_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            freq_cnt_q <= freq_cnt_d;
            freq_ovf_q <= freq_ovf_d;
            freq_vld_q <= freq_vld_d;
`ifdef FREQ_METER_BCD_EN
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            conv_cnt_q <= conv_cnt_d;
            freq_bcd_q <= freq_bcd_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign freq_cnt = freq_cnt_q;
    assign freq_ovf = freq_ovf_q;
    assign freq_vld = freq_vld_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances (normal, 4-bit saturating, continuous) with randomized periodic inputs.
module tb_freq_meter;

    localparam int GA = 100;
`ifdef FREQ_METER_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [2:0]  rst_v, start_v, sig_v;
    logic        busy_a, busy_b, busy_c, vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c;
    logic [2:0]  busy_v, vld_v;
    logic [23:0] cnt_a, cnt_c;
    logic [3:0]  cnt_b;
    logic [31:0] bcd_a, bcd_b, bcd_c;

    int tests = 0;
    int fails = 0;
    bit hold[3];
    bit hold_val[3];
    int hi[3], lo[3], ph[3];

    assign busy_v = {busy_c, busy_b, busy_a};
    assign vld_v  = {vld_c, vld_b, vld_a};

    freq_meter #(.GATE_CYCLES(GA), .CNT_W(24), .SYNC_STAGES(2), .CONTINUOUS(0)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_v[0]), .start(start_v[0]), .sig_in(sig_v[0]),
        .busy(busy_a), .freq_cnt(cnt_a), .freq_ovf(ovf_a), .freq_vld(vld_a), .freq_bcd(bcd_a));
    freq_meter #(.GATE_CYCLES(GA), .CNT_W(4), .SYNC_STAGES(2), .CONTINUOUS(0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_v[1]), .start(start_v[1]), .sig_in(sig_v[1]),
        .busy(busy_b), .freq_cnt(cnt_b), .freq_ovf(ovf_b), .freq_vld(vld_b), .freq_bcd(bcd_b));
    freq_meter #(.GATE_CYCLES(GA), .CNT_W(24), .SYNC_STAGES(2), .CONTINUOUS(1)) dut_c (
        .sys_clk(clk), .sys_rst_n(rst_v[2]), .start(start_v[2]), .sig_in(sig_v[2]),
        .busy(busy_c), .freq_cnt(cnt_c), .freq_ovf(ovf_c), .freq_vld(vld_c), .freq_bcd(bcd_c));

    initial forever #5 clk = ~clk;

    // Periodic sig generators: high for hi[i] cycles, low for lo[i] cycles, or held at a level.
    initial begin
        sig_v = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (hold[i]) begin
                    sig_v[i] = hold_val[i];
                    ph[i]    = 0;
                end else begin
                    ph[i]++;
                    if (sig_v[i] ? (ph[i] >= hi[i]) : (ph[i] >= lo[i])) begin
                        sig_v[i] = ~sig_v[i];
                        ph[i]    = 0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_bcd(input int v);
        return BCD ? to_bcd(v) : 32'd0;
    endfunction

    function automatic logic [23:0] get_cnt(input int sel);
        if (sel == 0) return cnt_a;
        if (sel == 1) return {20'd0, cnt_b};
        return cnt_c;
    endfunction

    // One measurement: returns cycles from start acceptance to freq_vld, busy-high cycles, mid-window count.
    task automatic run(input int sel, input bit extra, output int lat, output int busy_cyc,
                       output bit to, output logic [23:0] mid);
        @(posedge clk); #1 start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v[sel] = 1'b0;
        lat = 0; busy_cyc = 0; to = 1'b0; mid = '0;
        while (vld_v[sel] !== 1'b1 && !to) begin
            if (busy_v[sel] === 1'b1) busy_cyc++;
            if (lat == GA / 2) begin
                mid = get_cnt(sel);
                if (extra) start_v[sel] = 1'b1;
            end
            if (lat == GA / 2 + 1) start_v[sel] = 1'b0;
            if (lat > 1000) to = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        start_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy_a, busy_b, busy_c, vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c} !== 9'd0) begin
            fails++; $display("FAIL reset_flags: got %b required 0", {busy_a, busy_b, busy_c, vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c});
        end
        tests++;
        if ({cnt_a, cnt_b, cnt_c} !== 52'd0 || {bcd_a, bcd_b, bcd_c} !== 96'd0) begin
            fails++; $display("FAIL reset_values: cnt %h bcd %h required 0", {cnt_a, cnt_b, cnt_c}, {bcd_a, bcd_b, bcd_c});
        end
        rst_v = 3'b111;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: busy %b vld %b required 0 0", busy_a, vld_a);
        end
    endtask

    task automatic test_basic();
        int lat, bc; bit to; logic [23:0] mid;
        hold[0] = 1'b0; hi[0] = 2; lo[0] = 2;
        repeat (20) @(posedge clk);
        run(0, 1'b0, lat, bc, to, mid);
        tests++;
        if (to || lat != GA + 1 + (BCD ? 24 : 0)) begin
            fails++; $display("FAIL basic_latency: got %0d (timeout %0d) required %0d", lat, to, GA + 1 + (BCD ? 24 : 0));
        end
        tests++;
        if (bc != lat || busy_a !== 1'b0) begin
            fails++; $display("FAIL basic_busy: busy cycles %0d required %0d, busy at vld %b", bc, lat, busy_a);
        end
        tests++;
        if (cnt_a !== 24'd25 || ovf_a !== 1'b0 || bcd_a !== exp_bcd(25)) begin
            fails++; $display("FAIL basic_result: cnt %0d ovf %b bcd %h required 25 0 %h", cnt_a, ovf_a, bcd_a, exp_bcd(25));
        end
        @(posedge clk); #1;
        tests++;
        if (vld_a !== 1'b0 || cnt_a !== 24'd25) begin
            fails++; $display("FAIL basic_pulse: vld %b cnt %0d required 0 25", vld_a, cnt_a);
        end
    endtask

    task automatic test_levels();
        int lat, bc; bit to; logic [23:0] mid;
        for (int lv = 1; lv >= 0; lv--) begin
            hold[0] = 1'b1; hold_val[0] = lv[0];
            repeat (20) @(posedge clk);
            run(0, 1'b0, lat, bc, to, mid);
            tests++;
            if (to || cnt_a !== 24'd0 || ovf_a !== 1'b0 || bcd_a !== 32'd0) begin
                fails++; $display("FAIL level_%0d: timeout %0d cnt %0d ovf %b bcd %h required 0", lv, to, cnt_a, ovf_a, bcd_a);
            end
        end
        hold[0] = 1'b0;
    endtask

    task automatic test_saturation();
        int lat, bc; bit to; logic [23:0] mid;
        int per[2] = '{4, 20};
        for (int k = 0; k < 2; k++) begin
            int edges, ecnt;
            bit eovf;
            hi[1] = per[k] / 2; lo[1] = per[k] / 2;
            repeat (60) @(posedge clk);
            run(1, 1'b0, lat, bc, to, mid);
            edges = GA / per[k];
            ecnt  = (edges > 15) ? 15 : edges;
            eovf  = (edges > 15);
            tests++;
            if (to || lat != GA + 1 + (BCD ? 4 : 0)) begin
                fails++; $display("FAIL sat_latency_%0d: got %0d required %0d", per[k], lat, GA + 1 + (BCD ? 4 : 0));
            end
            tests++;
            if (cnt_b !== 4'(ecnt) || ovf_b !== eovf || bcd_b !== exp_bcd(ecnt)) begin
                fails++; $display("FAIL sat_result_%0d: cnt %0d ovf %b bcd %h required %0d %b %h", per[k], cnt_b, ovf_b, bcd_b, ecnt, eovf, exp_bcd(ecnt));
            end
        end
    endtask

    task automatic test_abort();
        int lat, bc, n_vld, n_busy; bit to; logic [23:0] mid;
        hold[0] = 1'b0; hi[0] = 2; lo[0] = 2;
        repeat (20) @(posedge clk);
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (50) @(posedge clk);
        #2 rst_v[0] = 1'b0;
        #1;
        tests++;
        if (busy_a !== 1'b0 || cnt_a !== 24'd0 || ovf_a !== 1'b0 || vld_a !== 1'b0 || bcd_a !== 32'd0) begin
            fails++; $display("FAIL abort_reset: busy %b cnt %0d ovf %b vld %b bcd %h required all 0", busy_a, cnt_a, ovf_a, vld_a, bcd_a);
        end
        repeat (3) @(posedge clk);
        #1 rst_v[0] = 1'b1;
        n_vld = 0; n_busy = 0;
        repeat (GA + 40) begin
            @(posedge clk); #1;
            if (vld_a === 1'b1) n_vld++;
            if (busy_a === 1'b1) n_busy++;
        end
        tests++;
        if (n_vld != 0 || n_busy != 0) begin
            fails++; $display("FAIL abort_quiet: vld %0d busy %0d cycles required 0 0", n_vld, n_busy);
        end
        run(0, 1'b0, lat, bc, to, mid);
        tests++;
        if (to || cnt_a !== 24'd25 || ovf_a !== 1'b0) begin
            fails++; $display("FAIL abort_rerun: timeout %0d cnt %0d ovf %b required 0 25 0", to, cnt_a, ovf_a);
        end
    endtask

    // Periods dividing the window give the same edge count for any phase.
    task automatic test_random();
        int plist[6] = '{4, 5, 10, 20, 25, 50};
        int prev = 25;
        for (int it = 0; it < 8; it++) begin
            int p, lat, bc, exp_cnt; bit to, extra; logic [23:0] mid;
            p = plist[$urandom_range(0, 5)];
            hi[0] = $urandom_range(2, p - 2);
            lo[0] = p - hi[0];
            exp_cnt = GA / p;
            extra = 1'($urandom_range(0, 1));
            repeat (120 + $urandom_range(0, 30)) @(posedge clk);
            run(0, extra, lat, bc, to, mid);
            tests++;
            if (mid !== 24'(prev)) begin
                fails++; $display("FAIL rand_hold_%0d: mid-window cnt %0d required %0d", it, mid, prev);
            end
            tests++;
            if (to || lat != GA + 1 + (BCD ? 24 : 0)) begin
                fails++; $display("FAIL rand_latency_%0d: got %0d required %0d (extra start %0d)", it, lat, GA + 1 + (BCD ? 24 : 0), extra);
            end
            tests++;
            if (cnt_a !== 24'(exp_cnt) || ovf_a !== 1'b0 || bcd_a !== exp_bcd(exp_cnt)) begin
                fails++; $display("FAIL rand_result_%0d: period %0d hi %0d cnt %0d ovf %b bcd %h required %0d 0 %h", it, p, hi[0], cnt_a, ovf_a, bcd_a, exp_cnt, exp_bcd(exp_cnt));
            end
            prev = exp_cnt;
        end
    endtask

    task automatic test_continuous();
        int n, gap;
        n = 0;
        while (vld_c !== 1'b1 && n < 400) begin
            start_v[2] = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++; $display("FAIL cont_first: no freq_vld within %0d cycles", n);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cnt_c !== 24'd10 || ovf_c !== 1'b0 || bcd_c !== exp_bcd(10)) begin
                fails++; $display("FAIL cont_result_%0d: cnt %0d ovf %b bcd %h required 10 0 %h", k, cnt_c, ovf_c, bcd_c, exp_bcd(10));
            end
            gap = 0;
            do begin
                start_v[2] = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
                gap++;
            end while (vld_c !== 1'b1 && gap < 400);
            tests++;
            if (gap != GA + 2 + (BCD ? 24 : 0)) begin
                fails++; $display("FAIL cont_interval_%0d: got %0d required %0d", k, gap, GA + 2 + (BCD ? 24 : 0));
            end
        end
        start_v[2] = 1'b0;
    endtask

    initial begin
        rst_v = 3'b000;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            hold[i] = 1'b0; hold_val[i] = 1'b0; hi[i] = 2; lo[i] = 2; ph[i] = 0;
        end
        hi[2] = 5; lo[2] = 5;
        test_reset();
        test_basic();
        test_levels();
        test_saturation();
        test_abort();
        test_random();
        test_continuous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a clock-like signal, such as a PLL output routed back to fabric, a divided clock or an external pin, against the board system clock.
- Counts rising edges of the measured signal during a gate window of fixed length in system-clock cycles.
- Reports the count, an overflow flag and a valid strobe.
- Feeds the seven-segment display path and the PLL bring-up checks.

Parameters:
- GATE_CYCLES, 12000000, gate window length in sys_clk cycles (1 s at 12 MHz, so the count reads in Hz).
- CNT_W, 24, width of the edge counter and of freq_cnt.
- SYNC_STAGES, 2, number of synchronizer flops on sig_in (minimum 2).
- CONTINUOUS, 0, when 1 the block re-arms automatically after each result and ignores start.

Ports:
- sys_clk  input  1  system clock (12 MHz board oscillator).
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin one measurement (ignored when CONTINUOUS=1).
- sig_in  input  1  measured signal, asynchronous to sys_clk.
- busy  output  1  high from gate start until the result is published.
- freq_cnt  output  CNT_W  rising edges counted in the last gate window, saturating.
- freq_ovf  output  1  high if the last window's count saturated.
- freq_vld  output  1  one-cycle strobe when freq_cnt, freq_ovf (and freq_bcd) update.
- freq_bcd  output  32  8-digit packed BCD of freq_cnt; driven to 0 when the BCD feature is off.

Behaviour:
- Clock and reset
  - One clock: sys_clk. Reset sys_rst_n is asynchronous, active-low.
  - Every flop clears on reset.
  - Output reset values: busy=0, freq_cnt=0, freq_ovf=0, freq_vld=0, freq_bcd=0. State=IDLE.
- Input conditioning
  - sig_in passes through SYNC_STAGES flops, then one delay flop.
  - edge = sync_out & ~delayed, one cycle per rising edge.
  - Guaranteed counting requires high and low phases of at least 2 sys_clk cycles each (f_sig <= sys_clk/4). Faster inputs are undefined and may undercount.
- States: IDLE, GATE, DONE, plus CONV when the BCD feature is enabled.
- IDLE
  - busy=0.
  - On start=1 (or every cycle when CONTINUOUS=1): go to GATE, clear gate_cnt and edge_cnt and the internal ovf flag.
- GATE
  - busy=1. gate_cnt increments every cycle.
  - Each edge increments edge_cnt.
  - At all-ones, edge_cnt holds and ovf is set.
  - Transition to DONE on the cycle gate_cnt==GATE_CYCLES-1. An edge in that final cycle is counted.
  - The window is exactly GATE_CYCLES cycles.
  - start during GATE, DONE or CONV is ignored. It is not queued.
- DONE (one cycle)
  - Without BCD: register freq_cnt<=edge_cnt and freq_ovf<=ovf. Assert freq_vld the following cycle, aligned with the new values. Then go to IDLE.
  - With BCD: go to CONV instead.
- Latency: freq_vld rises 2 cycles after the last gate cycle (non-BCD).
- Continuous mode: one IDLE cycle between windows, so results arrive every GATE_CYCLES+2 cycles.
- Between strobes, freq_cnt, freq_ovf and freq_bcd hold their last values.
- Sizing: gate_cnt width is clog2(GATE_CYCLES), minimum 1. GATE_CYCLES must be at least 2.
- Reset mid-measurement aborts immediately. No freq_vld is produced, and outputs return to reset values.

Optional Feature:
- Macro: FREQ_METER_BCD_EN.
- When defined:
  - DONE latches edge_cnt into a shift register and enters CONV.
  - CONV runs a sequential double-dabble, one bit per cycle for CNT_W cycles. Before each shift, add 3 to every digit that is 5 or more.
  - busy stays 1 through CONV.
  - After the last shift, freq_cnt, freq_ovf and freq_bcd update together. freq_vld pulses the next cycle. State returns to IDLE.
  - A saturated count converts the saturated value.
  - Non-BCD latency plus CNT_W cycles.
- When undefined: no CONV state, no converter logic, freq_bcd tied to 0.

Test Plan:
- GATE_CYCLES=100, CNT_W=24, sig_in period 4 cycles (2 high/2 low), single start pulse -> one freq_vld, freq_cnt=25, freq_ovf=0, busy high for the window.
- sig_in held at 1, then held at 0, across a window -> freq_cnt=0 both times, freq_vld asserted each time.
- CNT_W=4, GATE_CYCLES=100, period 4 -> freq_cnt=15, freq_ovf=1. A following window with period 20 -> freq_cnt=5, freq_ovf=0.
- sys_rst_n pulsed low at gate cycle 50 -> busy=0 and freq_cnt=0 immediately, no freq_vld. A new start afterwards gives a correct 25.
- CONTINUOUS=1, GATE_CYCLES=100, period 10 -> freq_vld every 102 cycles, each with freq_cnt=10. start pulses have no effect.
- FREQ_METER_BCD_EN defined, period 4, GATE_CYCLES=100 -> freq_bcd=32'h00000025, freq_vld exactly 24 cycles later than the non-BCD build.
